// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - parity modes, shared FSM state encoding and parity helper for the UART
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  // Callers zero-extend narrower words; the extra zeros do not change the ones count.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic [1:0] mode);
    case (mode)
      PARITY_ODD:  return ~^data;
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter with clear, mid-point and end-of-bit strobes
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_mid,
  output logic o_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  // Saturates at LAST; users restart each bit with i_clear.
  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_mid = (count_q == MID);
  assign o_end = (count_q == LAST);

endmodule

// File: rtl/uart_xcvr_cfg.sv
// rtl/uart_xcvr_cfg.sv - full-duplex UART with configurable data width, parity and stop bits
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around each RX sample point.
module uart_xcvr_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_serial,
  input  logic                 i_rx_serial,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam bit HAS_PAR = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam logic [1:0] PMODE = HAS_PAR ? 2'(PARITY_MODE) : PARITY_NONE;
  localparam bit TWO_STOP = (STOP_BITS == 2);

  uart_state_e          tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic [IW-1:0]        tx_idx_q, tx_idx_d;
  logic                 tx_par_q, tx_par_d, tx_stop_q, tx_stop_d;
  logic                 tx_serial_q, tx_serial_d, tx_ready_q, tx_ready_d;
  logic                 tx_clear, tx_end, tx_mid_unused;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(tx_clear), .o_mid(tx_mid_unused), .o_end(tx_end)
  );

  // The data word shifts right so the next bit is always at index 1; parity is fixed at accept time.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    tx_par_d    = tx_par_q;
    tx_idx_d    = tx_idx_q;
    tx_stop_d   = tx_stop_q;
    tx_serial_d = tx_serial_q;
    tx_clear    = tx_end;
    case (tx_state_q)
      ST_IDLE: begin
        tx_clear = 1'b1;
        if (i_tx_valid) begin
          tx_data_d   = i_tx_data;
          tx_par_d    = parity_bit(MAX_DATA_BITS'(i_tx_data), PMODE);
          tx_state_d  = ST_START;
          tx_serial_d = 1'b0;
        end
      end
      ST_START: if (tx_end) begin
        tx_state_d  = ST_DATA;
        tx_idx_d    = '0;
        tx_serial_d = tx_data_q[0];
      end
      ST_DATA: if (tx_end) begin
        if (tx_idx_q == LAST_IDX) begin
          tx_stop_d   = 1'b0;
          tx_serial_d = HAS_PAR ? tx_par_q : 1'b1;
          if (HAS_PAR) tx_state_d = ST_PARITY;
          else         tx_state_d = ST_STOP;
        end else begin
          tx_idx_d    = tx_idx_q + IW'(1);
          tx_data_d   = tx_data_q >> 1;
          tx_serial_d = tx_data_q[1];
        end
      end
      ST_PARITY: if (tx_end) begin
        tx_state_d  = ST_STOP;
        tx_stop_d   = 1'b0;
        tx_serial_d = 1'b1;
      end
      ST_STOP: if (tx_end) begin
        if (TWO_STOP && !tx_stop_q) tx_stop_d  = 1'b1;
        else                        tx_state_d = ST_IDLE;
      end
      default: begin
        tx_state_d  = ST_IDLE;
        tx_serial_d = 1'b1;
      end
    endcase
    tx_ready_d = (tx_state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state_q  <= ST_IDLE;
      tx_data_q   <= '0;
      tx_par_q    <= 1'b0;
      tx_idx_q    <= '0;
      tx_stop_q   <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_ready_q  <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      tx_par_q    <= tx_par_d;
      tx_idx_q    <= tx_idx_d;
      tx_stop_q   <= tx_stop_d;
      tx_serial_q <= tx_serial_d;
      tx_ready_q  <= tx_ready_d;
    end
  end

  assign o_tx_ready  = tx_ready_q;
  assign o_tx_serial = tx_serial_q;

  logic [1:0] rx_sync_q, rx_sync_d;
  logic       rx_line, rx_clear, rx_mid, rx_end, rx_samp, rx_bit;

  assign rx_sync_d = {rx_sync_q[0], i_rx_serial};
  assign rx_line   = rx_sync_q[1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rx_sync_q <= 2'b11;
    else       rx_sync_q <= rx_sync_d;
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(rx_clear), .o_mid(rx_mid), .o_end(rx_end)
  );

`ifdef UART_RX_MAJORITY_EN
  // Decide one cycle after mid, voting over the line at mid-1, mid and mid+1.
  logic [1:0] rx_hist_q, rx_hist_d;
  logic       rx_mid_dly_q, rx_mid_dly_d;

  assign rx_hist_d    = {rx_hist_q[0], rx_line};
  assign rx_mid_dly_d = rx_mid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_hist_q    <= 2'b11;
      rx_mid_dly_q <= 1'b0;
    end else begin
      rx_hist_q    <= rx_hist_d;
      rx_mid_dly_q <= rx_mid_dly_d;
    end
  end

  assign rx_samp = rx_mid_dly_q;
  assign rx_bit  = (rx_hist_q[1] & rx_hist_q[0]) | (rx_hist_q[1] & rx_line) | (rx_hist_q[0] & rx_line);
`else
  assign rx_samp = rx_mid;
  assign rx_bit  = rx_line;
`endif

  uart_state_e          rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
  logic [IW-1:0]        rx_idx_q, rx_idx_d;
  logic                 rx_stop_q, rx_stop_d, rx_perr_acc_q, rx_perr_acc_d, rx_ferr_acc_q, rx_ferr_acc_d;
  logic                 rx_valid_q, rx_valid_d, rx_parity_err_q, rx_parity_err_d;
  logic                 rx_frame_err_q, rx_frame_err_d;

  // The timer restarts at each bit boundary, so every sample falls exactly one bit after the last.
  always_comb begin
    rx_state_d      = rx_state_q;
    rx_shift_d      = rx_shift_q;
    rx_idx_d        = rx_idx_q;
    rx_stop_d       = rx_stop_q;
    rx_perr_acc_d   = rx_perr_acc_q;
    rx_ferr_acc_d   = rx_ferr_acc_q;
    rx_data_d       = rx_data_q;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d  = rx_frame_err_q;
    rx_valid_d      = 1'b0;
    rx_clear        = rx_end || (rx_state_q == ST_IDLE) || (rx_state_q == ST_WAIT_HIGH);
    case (rx_state_q)
      ST_IDLE: if (!rx_line) rx_state_d = ST_START;
      ST_START: if (rx_samp) begin
        if (rx_bit) begin
          rx_state_d = ST_IDLE;
        end else begin
          rx_state_d    = ST_DATA;
          rx_idx_d      = '0;
          rx_stop_d     = 1'b0;
          rx_perr_acc_d = 1'b0;
          rx_ferr_acc_d = 1'b0;
        end
      end
      ST_DATA: if (rx_samp) begin
        rx_shift_d = {rx_bit, rx_shift_q[DATA_BITS-1:1]};
        if (rx_idx_q == LAST_IDX) begin
          if (HAS_PAR) rx_state_d = ST_PARITY;
          else         rx_state_d = ST_STOP;
        end else begin
          rx_idx_d = rx_idx_q + IW'(1);
        end
      end
      ST_PARITY: if (rx_samp) begin
        rx_perr_acc_d = (rx_bit != parity_bit(MAX_DATA_BITS'(rx_shift_q), PMODE));
        rx_state_d    = ST_STOP;
      end
      ST_STOP: if (rx_samp) begin
        if (TWO_STOP && !rx_stop_q) begin
          rx_stop_d     = 1'b1;
          rx_ferr_acc_d = rx_ferr_acc_q | ~rx_bit;
        end else begin
          rx_valid_d      = 1'b1;
          rx_data_d       = rx_shift_q;
          rx_parity_err_d = rx_perr_acc_q;
          rx_frame_err_d  = rx_ferr_acc_q | ~rx_bit;
          if (rx_ferr_acc_q | ~rx_bit) rx_state_d = ST_WAIT_HIGH;
          else                         rx_state_d = ST_IDLE;
        end
      end
      ST_WAIT_HIGH: if (rx_line) rx_state_d = ST_IDLE;
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state_q      <= ST_IDLE;
      rx_shift_q      <= '0;
      rx_idx_q        <= '0;
      rx_stop_q       <= 1'b0;
      rx_perr_acc_q   <= 1'b0;
      rx_ferr_acc_q   <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
    end else begin
      rx_state_q      <= rx_state_d;
      rx_shift_q      <= rx_shift_d;
      rx_idx_q        <= rx_idx_d;
      rx_stop_q       <= rx_stop_d;
      rx_perr_acc_q   <= rx_perr_acc_d;
      rx_ferr_acc_q   <= rx_ferr_acc_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
    end
  end

  assign o_rx_data       = rx_data_q;
  assign o_rx_valid      = rx_valid_q;
  assign o_rx_parity_err = rx_parity_err_q;
  assign o_rx_frame_err  = rx_frame_err_q;

endmodule

// File: tb/tb_uart_xcvr_cfg.sv
// tb/tb_uart_xcvr_cfg.sv - scoreboard bench: 8E1 loopback and driven RX frames, plus a 5O2 instance
module tb_uart_xcvr_cfg;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_serial, rx_serial, rx_valid, rx_perr, rx_ferr;
  logic [7:0] rx_data;
  logic       loop = 1'b1;
  logic       drv = 1'b1;

  logic [4:0] tx_data5 = '0;
  logic       tx_valid5 = 1'b0;
  logic       tx_ready5, tx_serial5, rx_valid5, rx_perr5, rx_ferr5;
  logic [4:0] rx_data5;

  int   tests = 0;
  int   fails = 0;
  exp_t sb8[$];
  exp_t sb5[$];
  bit   fbits[$];

  assign rx_serial = loop ? tx_serial : drv;

  always #5 clk = ~clk;

  uart_xcvr_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_tx_serial(tx_serial), .i_rx_serial(rx_serial), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .o_rx_parity_err(rx_perr), .o_rx_frame_err(rx_ferr)
  );

  uart_xcvr_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_MODE(1), .STOP_BITS(2)) dut5 (
    .i_clk(clk), .i_rst(rst), .i_tx_data(tx_data5), .i_tx_valid(tx_valid5), .o_tx_ready(tx_ready5),
    .o_tx_serial(tx_serial5), .i_rx_serial(tx_serial5), .o_rx_data(rx_data5), .o_rx_valid(rx_valid5),
    .o_rx_parity_err(rx_perr5), .o_rx_frame_err(rx_ferr5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: parity from a plain ones count.
  function automatic bit exp_par(input logic [8:0] d, input int nb, input int mode);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    if (mode == 1) return (ones % 2) == 0;
    if (mode == 2) return (ones % 2) == 1;
    return 1'b0;
  endfunction

  task automatic build_frame(input logic [8:0] d, input int nb, input int mode, input int stops,
                             input bit par_flip, input bit stop_flip);
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < nb; i++) fbits.push_back(d[i]);
    if (mode == 1 || mode == 2) fbits.push_back(exp_par(d, nb, mode) ^ par_flip);
    for (int s = 0; s < stops; s++) fbits.push_back(!(stop_flip && s == 0));
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? tx_ready5 : tx_ready;
  endfunction

  function automatic logic ser(input bit sel);
    return sel ? tx_serial5 : tx_serial;
  endfunction

  task automatic tx_send(input bit sel, input logic [8:0] d, input logic [8:0] nxt, input bit hold);
    int t = 0;
    int zc = 0;
    bit q[$];
    if (sel) build_frame(d, 5, 1, 2, 1'b0, 1'b0);
    else     build_frame(d, 8, 2, 1, 1'b0, 1'b0);
    q = fbits;
    while (!rdy(sel) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", rdy(sel), 1);
    if (sel) begin
      tx_valid5 = 1'b1; tx_data5 = d[4:0]; sb5.push_back({d, 1'b0, 1'b0});
    end else begin
      tx_valid = 1'b1; tx_data = d[7:0]; sb8.push_back({d, 1'b0, 1'b0});
    end
    @(negedge clk);
    if (sel) begin
      if (hold) tx_data5 = nxt[4:0]; else tx_valid5 = 1'b0;
    end else begin
      if (hold) tx_data = nxt[7:0]; else tx_valid = 1'b0;
    end
    for (int n = 0; n < q.size() * CPB; n++) begin
      if (n == 0) check("tx_start_edge", ser(sel), 0);
      if (n % CPB == CPB / 2) check("tx_bit", ser(sel), q[n / CPB]);
      if (!rdy(sel)) zc++;
      @(negedge clk);
    end
    check("tx_busy_cycles", zc, q.size() * CPB);
    check("tx_idle_ready", rdy(sel), 1);
    check("tx_idle_line", ser(sel), 1);
  endtask

  task automatic drive_frame(input logic [8:0] d, input bit pf, input bit sf);
    build_frame(d, 8, 2, 1, pf, sf);
    sb8.push_back({d, pf, sf});
    loop = 1'b0;
    foreach (fbits[i]) begin
      drv = fbits[i];
      repeat (CPB) @(negedge clk);
    end
    drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rx_valid) begin
      if (sb8.size() == 0) begin
        check("rx8_unexpected_report", rx_valid, 0);
      end else begin
        e = sb8.pop_front();
        check("rx8_data", {1'b0, rx_data}, e.d);
        check("rx8_parity_err", rx_perr, e.pe);
        check("rx8_frame_err", rx_ferr, e.fe);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && rx_valid5) begin
      if (sb5.size() == 0) begin
        check("rx5_unexpected_report", rx_valid5, 0);
      end else begin
        e = sb5.pop_front();
        check("rx5_data", {4'b0, rx_data5}, e.d);
        check("rx5_parity_err", rx_perr5, e.pe);
        check("rx5_frame_err", rx_ferr5, e.fe);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx_serial", tx_serial, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_parity_err", rx_perr, 0);
    check("rst_rx_frame_err", rx_ferr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    tx_send(1'b0, 9'h0A5, 9'h000, 1'b0);
    repeat (8) tx_send(1'b0, 9'($urandom_range(0, 255)), 9'h000, 1'b0);

    drive_frame(9'h03C, 1'b1, 1'b0);

    // Break: zero frame whose stop bit is low, line held low for 40 bit times.
    sb8.push_back({9'h000, 1'b0, 1'b1});
    loop = 1'b0;
    drv = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    drive_frame(9'($urandom_range(0, 255)), 1'b0, 1'b0);

    repeat (8) drive_frame(9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    drv = 1'b0;
    repeat (3) @(negedge clk);
    drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);

`ifdef UART_RX_MAJORITY_EN
    for (int k = 0; k < 4; k++) begin
      logic [8:0] gd;
      gd = 9'($urandom_range(0, 255));
      build_frame(gd, 8, 2, 1, 1'b0, 1'b0);
      sb8.push_back({gd, 1'b0, 1'b0});
      foreach (fbits[i]) begin
        for (int c = 0; c < CPB; c++) begin
          drv = (c == CPB / 2 + 1) ? ~fbits[i] : fbits[i];
          @(negedge clk);
        end
      end
      drv = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
`endif

    loop = 1'b1;
    repeat (2) @(negedge clk);
    tx_valid = 1'b1;
    tx_data = 8'($urandom_range(0, 255));
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    check("tx_busy_before_reset", tx_ready, 0);
    rst = 1'b1;
    #1;
    check("midframe_rst_tx_serial", tx_serial, 1);
    check("midframe_rst_tx_ready", tx_ready, 1);
    check("midframe_rst_rx_valid", rx_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15 * CPB) @(negedge clk);

    tx_send(1'b1, 9'h015, 9'h00A, 1'b1);
    tx_send(1'b1, 9'h00A, 9'h000, 1'b0);

    for (int t = 0; t < 4000 && (sb8.size() != 0 || sb5.size() != 0); t++) @(negedge clk);
    check("sb8_drained", sb8.size(), 0);
    check("sb5_drained", sb5.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
